// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter: round-robin I/D cacheline arbiter onto a single registered memory port
module cache_line_arbiter #(
  parameter int s_offset = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          imem_address,
  input  logic                 imem_read,
  output logic [255:0]         imem_rdata,
  output logic                 imem_resp,
  input  logic [31:0]          dmem_address,
  input  logic                 dmem_read,
  input  logic                 dmem_write,
  input  logic [255:0]         dmem_wdata,
  output logic [255:0]         dmem_rdata,
  output logic                 dmem_resp,
  output logic [31:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [255:0]         pmem_wdata,
  input  logic [255:0]         pmem_rdata,
  input  logic                 pmem_resp,
  output logic                 arbiter_idle,
  output logic [CNT_WIDTH-1:0] i_grant_count,
  output logic [CNT_WIDTH-1:0] d_grant_count
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;
  state_t state, state_next;
  logic last_d, op_write, i_req, d_req, grant_i, grant_d;
  always_comb begin
    i_req = imem_read;
    d_req = dmem_read | dmem_write;
    grant_i = state == IDLE && i_req && !(d_req && !last_d);
    grant_d = state == IDLE && d_req && !grant_i;
    state_next = grant_i ? SERVE_I :
                 grant_d ? SERVE_D :
                 state == DONE ? IDLE :
                 (state == SERVE_I || state == SERVE_D) && pmem_resp ? DONE : state;
    pmem_read = state == SERVE_I || (state == SERVE_D && !op_write);
    pmem_write = state == SERVE_D && op_write;
    imem_resp = state == SERVE_I && pmem_resp;
    dmem_resp = state == SERVE_D && pmem_resp;
    imem_rdata = pmem_rdata;
    dmem_rdata = pmem_rdata;
    arbiter_idle = state == IDLE && !i_req && !d_req;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_d <= 1'b1;
      op_write <= 1'b0;
      pmem_address <= '0;
      pmem_wdata <= '0;
      i_grant_count <= '0;
      d_grant_count <= '0;
    end else begin
      state <= state_next;
      if (grant_i || grant_d) begin
        pmem_address <= {grant_i ? imem_address[31:s_offset] : dmem_address[31:s_offset], s_offset'(1'b0)};
        last_d <= grant_d;
      end
      if (grant_d) begin
        pmem_wdata <= dmem_wdata;
        op_write <= dmem_write;
      end
      if (grant_i) i_grant_count <= i_grant_count + CNT_WIDTH'(i_grant_count != '1);
      if (grant_d) d_grant_count <= d_grant_count + CNT_WIDTH'(d_grant_count != '1);
    end
  end
endmodule

// File: tb/tb_cache_line_arbiter.sv
// tb_cache_line_arbiter: randomized transaction-level check of cache_line_arbiter against a behavioural model
module tb_cache_line_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] imem_address, dmem_address, pmem_address, s_paddr;
  logic imem_read, dmem_read, dmem_write, pmem_resp;
  logic [255:0] dmem_wdata, pmem_rdata, imem_rdata, dmem_rdata, pmem_wdata;
  logic [255:0] s_irdata, s_drdata, s_pwdata;
  logic imem_resp, dmem_resp, pmem_read, pmem_write, arbiter_idle;
  logic s_iresp, s_dresp, s_pr, s_pw, s_idle;
  logic [15:0] i_grant_count, d_grant_count;
  logic [1:0] s_icnt, s_dcnt;
  int n_chk = 0, n_pass = 0;
  bit last_d;
  int ni, nd;
  logic [31:0] e_addr;
  logic [255:0] e_wdata;
  always #5 clk = ~clk;
  cache_line_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_address(imem_address), .imem_read(imem_read), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arbiter_idle(arbiter_idle), .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
  );
  cache_line_arbiter #(.CNT_WIDTH(2)) sat (
    .clk(clk), .rst(rst),
    .imem_address(imem_address), .imem_read(imem_read), .imem_rdata(s_irdata), .imem_resp(s_iresp),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_wdata(dmem_wdata),
    .dmem_rdata(s_drdata), .dmem_resp(s_dresp),
    .pmem_address(s_paddr), .pmem_read(s_pr), .pmem_write(s_pw), .pmem_wdata(s_pwdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arbiter_idle(s_idle), .i_grant_count(s_icnt), .d_grant_count(s_dcnt)
  );
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    last_d = 1'b1;
    ni = 0;
    nd = 0;
    e_addr = '0;
    e_wdata = '0;
  endtask
  task automatic chk_counts();
    chk("cnt_i", 256'(i_grant_count), 256'(ni));
    chk("cnt_d", 256'(d_grant_count), 256'(nd));
    chk("sat_i", 256'(s_icnt), 256'(ni > 3 ? 3 : ni));
    chk("sat_d", 256'(s_dcnt), 256'(nd > 3 ? 3 : nd));
  endtask
  task automatic scramble();
    imem_read = 1'($urandom_range(0, 1));
    dmem_read = 1'($urandom_range(0, 1));
    dmem_write = 1'($urandom_range(0, 1));
    imem_address = $urandom;
    dmem_address = $urandom;
    dmem_wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask
  task automatic xact(input bit ir, input bit dr, input bit dw, input logic [31:0] ia, input logic [31:0] da,
                      input logic [255:0] wd, input int lat, input logic [255:0] rd);
    bit gi, gd, wr;
    imem_read = ir;
    dmem_read = dr;
    dmem_write = dw;
    imem_address = ia;
    dmem_address = da;
    dmem_wdata = wd;
    pmem_resp = 1'($urandom_range(0, 1));
    pmem_rdata = rd;
    @(negedge clk);
    chk("idle", 256'(arbiter_idle), 256'(!(ir || dr || dw)));
    chk("stray_resp", 256'({imem_resp, dmem_resp}), 256'(0));
    chk("idle_strobes", 256'({pmem_read, pmem_write}), 256'(0));
    gi = ir && !((dr || dw) && !last_d);
    gd = (dr || dw) && !gi;
    if (!(gi || gd)) begin
      tick();
      return;
    end
    wr = gd && dw;
    e_addr = {(gi ? ia[31:5] : da[31:5]), 5'b0};
    if (gd) e_wdata = wd;
    last_d = gd;
    ni += int'(gi);
    nd += int'(gd);
    tick();
    for (int k = 0; k <= lat; k++) begin
      scramble();
      pmem_resp = (k == lat);
      pmem_rdata = rd;
      @(negedge clk);
      chk("pmem_read", 256'(pmem_read), 256'(gi || (gd && !wr)));
      chk("pmem_write", 256'(pmem_write), 256'(wr));
      chk("pmem_address", 256'(pmem_address), 256'(e_addr));
      chk("pmem_wdata", pmem_wdata, e_wdata);
      chk("imem_resp", 256'(imem_resp), 256'(gi && k == lat));
      chk("dmem_resp", 256'(dmem_resp), 256'(gd && k == lat));
      chk("serve_idle", 256'(arbiter_idle), 256'(0));
      if (k == lat) chk("rdata", gi ? imem_rdata : dmem_rdata, rd);
      chk_counts();
      tick();
    end
    scramble();
    pmem_resp = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("done_outputs", 256'({pmem_read, pmem_write, imem_resp, dmem_resp}), 256'(0));
    chk("done_idle", 256'(arbiter_idle), 256'(0));
    tick();
  endtask
  initial begin
    rst = 1'b1;
    imem_read = 1'b0;
    dmem_read = 1'b0;
    dmem_write = 1'b0;
    imem_address = '0;
    dmem_address = '0;
    dmem_wdata = '0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_strobes", 256'({pmem_read, pmem_write, imem_resp, dmem_resp}), 256'(0));
    chk("rst_idle", 256'(arbiter_idle), 256'(1));
    chk("rst_addr", 256'(pmem_address), 256'(0));
    chk("rst_wdata", pmem_wdata, 256'(0));
    chk_counts();
    tick();
    for (int j = 0; j < 4; j++)
      xact(1'b1, 1'b1, 1'b0, 32'h0000_1000 + 32'(j * 64), 32'h0000_2000 + 32'(j * 64), '0, 0, {8{$urandom}});
    xact(1'b1, 1'b0, 1'b0, 32'h0000_1234, '0, '0, 2, {32{8'hAB}});
    xact(1'b0, 1'b0, 1'b0, '0, '0, '0, 0, '0);
    xact(1'b0, 1'b0, 1'b1, '0, 32'h8000_0040, {32{8'h5A}}, 2, '0);
    xact(1'b0, 1'b1, 1'b1, '0, 32'h8000_0060, {32{8'h3C}}, 1, '0);
    dmem_write = 1'b1;
    dmem_address = 32'h4000_0080;
    dmem_wdata = {32{8'hC3}};
    imem_read = 1'b0;
    dmem_read = 1'b0;
    pmem_resp = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_write", 256'(pmem_write), 256'(1));
    tick();
    rst = 1'b0;
    dmem_write = 1'b0;
    pmem_resp = 1'b1;
    model_reset();
    @(negedge clk);
    chk("post_rst_outputs", 256'({pmem_read, pmem_write, imem_resp, dmem_resp}), 256'(0));
    chk("post_rst_addr", 256'(pmem_address), 256'(0));
    chk_counts();
    tick();
    for (int j = 0; j < 5; j++) xact(1'b1, 1'b0, 1'b0, $urandom, $urandom, '0, 0, {8{$urandom}});
    for (int j = 0; j < 80; j++)
      xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           int'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_line_arbiter.md
# cache_line_arbiter

Arbitrates cacheline traffic from the instruction-side path (I-cache, fed by the next-line prefetcher) and the data-side path (D-cache) onto the single physical-memory cacheline port. It registers each granted request, holds it stable toward memory until `pmem_resp`, and routes the response back to the requester. It also produces `arbiter_idle`, which the next-line prefetcher uses to start speculative fetches only when memory is free.

## Interface
Parameters:
- `s_offset`, default 5: log2 of the line size in bytes; `pmem_address` has its low `s_offset` bits forced to 0.
- `CNT_WIDTH`, default 16: width of each grant counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `imem_address` in 32: I-side line address.
- `imem_read` in 1: I-side read request.
- `imem_rdata` out 256: I-side read data.
- `imem_resp` out 1: I-side completion.
- `dmem_address` in 32: D-side line address.
- `dmem_read` in 1: D-side read request.
- `dmem_write` in 1: D-side write request (writeback).
- `dmem_wdata` in 256: D-side write line.
- `dmem_rdata` out 256: D-side read data.
- `dmem_resp` out 1: D-side completion.
- `pmem_address` out 32: memory line address, registered.
- `pmem_read` out 1: memory read strobe.
- `pmem_write` out 1: memory write strobe.
- `pmem_wdata` out 256: memory write line, registered.
- `pmem_rdata` in 256: memory read data.
- `pmem_resp` in 1: memory completion.
- `arbiter_idle` out 1: no transaction active or pending.
- `i_grant_count` out CNT_WIDTH: I grants since reset, saturating.
- `d_grant_count` out CNT_WIDTH: D grants since reset, saturating.

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE.
- **IDLE: request detection.**
  - I request = `imem_read`.
  - D request = `dmem_read | dmem_write`.
  - No request: stay in IDLE.
- **IDLE: grant selection.**
  - Only one side requesting: grant that side.
  - Both requesting: grant the side not equal to `last_grant`. This gives round-robin on ties.
  - `last_grant` resets to D, so the first tie goes to I.
- **On grant:**
  - Latch `{address[31:s_offset], s_offset'b0}` into the address register.
  - D side only: latch `dmem_wdata`, and latch the op as write if `dmem_write`, else read. `dmem_write` wins if both strobes are set.
  - Update `last_grant`.
  - Increment the granted side's counter. The counter saturates at all-ones.
- **SERVE_I:**
  - Drive `pmem_read`=1.
  - `imem_rdata` = `pmem_rdata`; `imem_resp` = `pmem_resp`.
  - On `pmem_resp`, go to DONE.
- **SERVE_D:**
  - Drive `pmem_read` or `pmem_write` per the latched op, never both.
  - `dmem_rdata` = `pmem_rdata`; `dmem_resp` = `pmem_resp`.
  - On `pmem_resp`, go to DONE.
- **DONE:**
  - One bubble cycle: no strobes, no grant. This lets the requester drop its request so it is not re-served.
  - Always go to IDLE next cycle.
- **Register stability:** requester inputs are ignored outside IDLE. Latched address and data must not change during SERVE_*.
- **`arbiter_idle`** = (state==IDLE) & no I request & no D request. Combinational.
- **Stray responses:** `pmem_resp` in IDLE or DONE is ignored; no `*_resp` is produced.
- **Non-granted side:** its `*_resp` stays 0. Its `*_rdata` is don't-care.

## Timing
- **Reset values:**
  - state IDLE; `last_grant` D.
  - Counters, address register and wdata register all 0.
  - `pmem_read`, `pmem_write`, `imem_resp`, `dmem_resp` all 0.
  - `arbiter_idle`=1 if there are no requests.
- **Grant latency:** request seen in IDLE at cycle t → SERVE_x and the `pmem` strobe asserted at t+1.
- **Response:** `pmem_resp` at cycle r (r ≥ t+1) → `*_resp`=1 in cycle r (same-cycle passthrough). The strobe is still high in r.
  - DONE at r+1.
  - IDLE at r+2; the earliest next grant is seen at r+2, with its strobe at r+3.
- **Minimum occupancy:** 3 cycles per transaction (SERVE, DONE, IDLE) when memory responds in 1 cycle.
- **Reset mid-transaction:** `rst` sampled high → next cycle is IDLE with all strobes 0. The in-flight transaction is dropped and no `*_resp` is issued for it.

## Test plan
- **Single I read:** `imem_read`, address 0x0000_1234 → `pmem_read`=1 with `pmem_address`=0x0000_1220 at t+1. `pmem_resp` with data 0xAB…AB at t+3 → `imem_resp`=1 and `imem_rdata`=0xAB…AB that cycle. `i_grant_count`=1.
- **Simultaneous I and D read after reset:** I is granted first, then D. Repeat the tie → I, D alternate. Both counters end at 2.
- **D write:** `dmem_write`, wdata 0x5A…5A, address 0x8000_0040. Drop `dmem_wdata` to 0 after grant → `pmem_write`=1 and `pmem_wdata` stays 0x5A…5A until resp. `pmem_read` stays 0 throughout.
- **Idle signal:**
  - `arbiter_idle`=1 with no requests.
  - `arbiter_idle`=0 in the same cycle `imem_read` rises.
  - `arbiter_idle`=0 through SERVE and DONE.
  - `arbiter_idle`=1 at r+2 once requests are low.
- **Reset mid-SERVE_D:** `rst` pulsed, then `pmem_resp` arrives → no `dmem_resp`. Strobes are 0 the cycle after `rst`. Counters read 0.
- **Saturation:** with CNT_WIDTH=2, 5 I grants → `i_grant_count`=3.
